// File: rtl/one_bit_adc.sv
`default_nettype none
// ============================================================================
//  Module      : one_bit_adc
//  Description : Digital half of a 1-bit delta-sigma audio ADC. Synchronises
//                the external comparator bit and returns it as the 1-bit
//                feedback DAC. A 3rd-order CIC decimator turns the bitstream
//                into signed q0.(W-1) PCM samples.
//  Revision    : 1.0  initial release
// ============================================================================
module one_bit_adc #(
  parameter int W        = 16,
  parameter int DEC_LOG2 = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clk_en,
  input  logic         comp_in,
  output logic         fb_out,
  output logic [W-1:0] sample_out,
  output logic         sample_valid
);

  // Integrator/comb width: enough headroom for R**3 plus sign.
  localparam int G     = 3*DEC_LOG2 + 2;
  // Scaling from CIC gain R**3 down to q0.(W-1); leaves exactly W+1 significant bits.
  localparam int SHIFT = 3*DEC_LOG2 - W + 1;

  localparam logic [DEC_LOG2-1:0] DEC_LAST   = {DEC_LOG2{1'b1}};
  localparam logic [2:0]          WARM_TICKS = 3'd4;

  localparam logic signed [G-1:0] Y_MAX = {{(G-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [G-1:0] Y_MIN = ~Y_MAX;

  localparam logic [W-1:0] OUT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] OUT_MIN = {1'b1, {(W-1){1'b0}}};

  localparam logic [G-1:0] X_POS = {{(G-1){1'b0}}, 1'b1};
  localparam logic [G-1:0] X_NEG = {G{1'b1}};

  // Synchroniser for the asynchronous comparator output
  logic s1;
  logic s2;

  // Modulator-rate state
  logic                bit_r;
  logic [G-1:0]        i1;
  logic [G-1:0]        i2;
  logic [G-1:0]        i3;
  logic [DEC_LOG2-1:0] dec_cnt;

  // Decimation capture and comb pipeline
  logic [G-1:0]        cap;
  logic [G-1:0]        c1;
  logic [G-1:0]        d1;
  logic [G-1:0]        c2;
  logic [G-1:0]        d2;
  logic signed [G-1:0] c3;
  logic [G-1:0]        d3;
  logic [3:0]          run;
  logic                emit_ok;
  logic [2:0]          warm;

  logic                tick;
  logic [G-1:0]        x;
  logic signed [G-1:0] y_full;

  assign tick   = clk_en && (dec_cnt == DEC_LAST);
  assign x      = s2 ? X_POS : X_NEG;
  assign y_full = c3 >>> SHIFT;
  assign fb_out = bit_r;

  // Two-flop synchroniser, free-running on every clk
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= comp_in;
      s2 <= s1;
    end
  end

  // Feedback bit, cascaded integrators and decimation counter at the clk_en rate
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_r   <= 1'b0;
      i1      <= '0;
      i2      <= '0;
      i3      <= '0;
      dec_cnt <= '0;
    end else if (clk_en) begin
      bit_r   <= s2;
      i1      <= i1 + x;
      i2      <= i2 + i1;
      i3      <= i3 + i2;
      dec_cnt <= dec_cnt + 1'b1;
    end
  end

  // Decimation tick: capture i3, launch the comb pipeline, track warm-up
  always_ff @(posedge clk) begin
    if (rst) begin
      cap     <= '0;
      run     <= '0;
      emit_ok <= 1'b0;
      warm    <= '0;
    end else begin
      run <= {run[2:0], tick};
      if (tick) begin
        cap     <= i3;
        emit_ok <= (warm == WARM_TICKS);
        if (warm != WARM_TICKS) begin
          warm <= warm + 3'd1;
        end
      end
    end
  end

  // Three comb stages, one per clk after the tick, independent of clk_en
  always_ff @(posedge clk) begin
    if (rst) begin
      c1 <= '0;
      d1 <= '0;
      c2 <= '0;
      d2 <= '0;
      c3 <= '0;
      d3 <= '0;
    end else begin
      if (run[0]) begin
        c1 <= cap - d1;
        d1 <= cap;
      end
      if (run[1]) begin
        c2 <= c1 - d2;
        d2 <= c1;
      end
      if (run[2]) begin
        c3 <= c2 - d3;
        d3 <= c2;
      end
    end
  end

  // Scale, saturate and publish the sample once warm-up is over
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= run[3] && emit_ok;
      if (run[3] && emit_ok) begin
        if (y_full > Y_MAX) begin
          sample_out <= OUT_MAX;
        end else if (y_full < Y_MIN) begin
          sample_out <= OUT_MIN;
        end else begin
          sample_out <= y_full[W-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_one_bit_adc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_one_bit_adc
//  Description : Directed self-checking bench for one_bit_adc (W=16,
//                DEC_LOG2=8). Drives comparator patterns, predicts the
//                tick/valid timing and the exact settled sample values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_one_bit_adc;

  localparam int R = 256;

  logic        clk;
  logic        rst;
  logic        clk_en;
  logic        comp_in;
  logic        fb_out;
  logic [15:0] sample_out;
  logic        sample_valid;

  int n_cmp;
  int n_err;

  one_bit_adc #(
    .W        (16),
    .DEC_LOG2 (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_en       (clk_en),
    .comp_in      (comp_in),
    .fb_out       (fb_out),
    .sample_out   (sample_out),
    .sample_valid (sample_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hold reset three clocks and check the cleared outputs.
  task automatic do_reset(input string name);
    rst     = 1'b1;
    clk_en  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq({name, ":rst_sample_out"}, 32'(sample_out), 32'h0);
    check_eq({name, ":rst_valid"}, 32'(sample_valid), 32'h0);
    check_eq({name, ":rst_fb_out"}, 32'(fb_out), 32'h0);
  endtask

  // A comparator edge must reach fb_out three clocks later.
  task automatic fb_latency_test();
    comp_in = 1'b0;
    do_reset("fb");
    rst    = 1'b0;
    clk_en = 1'b1;
    repeat (4) @(negedge clk);
    comp_in = 1'b1;
    @(negedge clk);
    check_eq("fb:edge+1", 32'(fb_out), 32'h0);
    @(negedge clk);
    check_eq("fb:edge+2", 32'(fb_out), 32'h0);
    @(negedge clk);
    check_eq("fb:edge+3", 32'(fb_out), 32'h1);
  endtask

  // Run one pattern: pat[0..plen-1] is applied one bit per clk_en, clk_en
  // fires once every 'div' clocks. Every valid is checked for its clock
  // position (4 clk after the 5th and later ticks) and its value. When
  // abort_tick > 0, reset is asserted on T+2 and T+3 of that tick and the
  // whole timing model restarts.
  task automatic run_case(input string name, input logic [3:0] pat, input int plen,
                          input int div, input int nval, input logic [15:0] expv,
                          input int abort_tick);
    int  edge_n;
    int  en_n;
    int  tick_n;
    int  tick_edge;
    int  got_n;
    int  exp_edge;
    int  budget;
    bit  aborted;
    comp_in = pat[0];
    do_reset(name);
    rst       = 1'b0;
    edge_n    = 0;
    en_n      = 0;
    tick_n    = 0;
    tick_edge = -1;
    got_n     = 0;
    exp_edge  = -1;
    aborted   = 1'b0;
    budget    = (5 + nval) * R * div + 64;
    clk_en    = 1'b1;
    comp_in   = pat[0];
    while (got_n < nval && edge_n < budget) begin
      @(negedge clk);
      edge_n++;
      if (clk_en) begin
        en_n++;
        if (en_n % R == 0) begin
          tick_n++;
          tick_edge = edge_n;
          if (tick_n == 5) exp_edge = edge_n + 4;
        end
      end
      if (sample_valid) begin
        check_eq({name, ":valid_clk"}, 32'(edge_n), 32'(exp_edge));
        check_eq({name, ":sample"}, 32'(sample_out), 32'(expv));
        got_n++;
        exp_edge = exp_edge + R * div;
      end else if (edge_n == exp_edge) begin
        check_eq({name, ":valid_missing"}, 32'(sample_valid), 32'h1);
        got_n++;
        exp_edge = exp_edge + R * div;
      end
      if (abort_tick > 0 && !aborted && tick_n == abort_tick && edge_n == tick_edge + 1) begin
        rst = 1'b1;
        @(negedge clk);
        check_eq({name, ":abort_t2_valid"}, 32'(sample_valid), 32'h0);
        @(negedge clk);
        check_eq({name, ":abort_sample_out"}, 32'(sample_out), 32'h0);
        check_eq({name, ":abort_fb_out"}, 32'(fb_out), 32'h0);
        check_eq({name, ":abort_valid"}, 32'(sample_valid), 32'h0);
        rst       = 1'b0;
        aborted   = 1'b1;
        edge_n    = 0;
        en_n      = 0;
        tick_n    = 0;
        tick_edge = -1;
        got_n     = 0;
        exp_edge  = -1;
      end
      clk_en  = (edge_n % div == 0);
      comp_in = pat[en_n % plen];
    end
    if (got_n < nval) begin
      check_eq({name, ":timeout_valids"}, 32'(got_n), 32'(nval));
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    rst     = 1'b1;
    clk_en  = 1'b0;
    comp_in = 1'b0;

    fb_latency_test();
    run_case("ones",     4'b0001, 1, 1, 3, 16'h7FFF, 0);
    run_case("zeros",    4'b0000, 1, 1, 2, 16'h8000, 0);
    run_case("toggle",   4'b0001, 2, 1, 2, 16'h0000, 0);
    run_case("p1110",    4'b0111, 4, 1, 2, 16'h4000, 0);
    run_case("abort",    4'b0001, 1, 1, 2, 16'h7FFF, 6);
    run_case("p1110_d4", 4'b0111, 4, 4, 2, 16'h4000, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
